// File: rtl/telemetry_frame_scheduler.sv
// Frame engine that streams "TO:R\r\n" telemetry bytes (seconds digits, separator, revolution
// digit, optional CRLF) to a valid/ready character sink on periodic or manual triggers.
module telemetry_frame_scheduler #(
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter logic [7:0]  SEP_CHAR    = 8'h3A,
  parameter bit          CRLF_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] tens_in,
  input  logic [6:0] ones_in,
  input  logic [6:0] rev_in,
  input  logic       send_req,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] overrun_cnt
);

  localparam int unsigned CntW    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [2:0]  LastIdx = CRLF_EN ? 3'd5 : 3'd3;

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] tick_cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      snap_tens_q, snap_ones_q, snap_rev_q;
  logic            pending_q;
  logic [7:0]      overrun_q;
  logic            tick, trig, start, xfer;

  function automatic logic [7:0] sanitize(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ? b : 8'h3F;
  endfunction

  assign tick  = (tick_cnt_q == CntW'(TICK_CYCLES - 1));
  assign trig  = tick | send_req;
  assign start = (state_q == StIdle) & (trig | pending_q);
  assign xfer  = tx_valid & tx_ready;

  // Tick generator runs regardless of FSM state.
  always_ff @(posedge clk) begin
    if (reset || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSend;
      StSend:  if (xfer && idx_q == LastIdx) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Snapshot, byte index and the single-entry trigger queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      snap_tens_q <= 8'h30;
      snap_ones_q <= 8'h30;
      snap_rev_q  <= 8'h30;
      pending_q   <= 1'b0;
      overrun_q   <= '0;
    end else begin
      if (start) begin
        snap_tens_q <= {1'b0, tens_in};
        snap_ones_q <= {1'b0, ones_in};
        snap_rev_q  <= {1'b0, rev_in};
        idx_q       <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + 3'd1;
      end
      if (start) begin
        pending_q <= 1'b0;
      end else if (state_q != StIdle && trig) begin
        if (!pending_q) begin
          pending_q <= 1'b1;
        end else if (overrun_q != 8'hFF) begin
          overrun_q <= overrun_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    tx_valid    = (state_q == StSend);
    frame_done  = (state_q == StDone);
    busy        = (state_q != StIdle);
    overrun_cnt = overrun_q;
    tx_data     = 8'h00;
    if (tx_valid) begin
      unique case (idx_q)
        3'd0:    tx_data = sanitize(snap_tens_q);
        3'd1:    tx_data = sanitize(snap_ones_q);
        3'd2:    tx_data = SEP_CHAR;
        3'd3:    tx_data = sanitize(snap_rev_q);
        3'd4:    tx_data = 8'h0D;
        3'd5:    tx_data = 8'h0A;
        default: tx_data = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/telemetry_frame_scheduler.md
Name: telemetry_frame_scheduler

Overview:
- Sequences the ASCII digit values (seconds tens/ones, revolution digit) into a byte stream for a shared serial character sink, typically the UART TX or LCD writer.
- Generates its own periodic frame trigger and accepts a manual send request, arbitrating both onto one frame engine.
- Snapshots the digits at frame start so a frame never tears.
- Emits bytes over a valid/ready handshake.

Parameters:
- TICK_CYCLES, 100000000: clock cycles between periodic frame triggers (1 Hz at 100 MHz); minimum 2.
- SEP_CHAR, 8'h3A: separator byte sent between the time and revolution fields (':').
- CRLF_EN, 1: 1 appends CR (8'h0D) and LF (8'h0A); 0 ends the frame after the revolution digit.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tens_in  input  7  ASCII tens-of-seconds digit.
- ones_in  input  7  ASCII ones-of-seconds digit.
- rev_in  input  7  ASCII revolution digit.
- send_req  input  1  manual frame request, sampled each cycle (level or pulse).
- tx_ready  input  1  sink can accept a byte this cycle.
- tx_data  output  8  current byte; bit 7 is always 0.
- tx_valid  output  1  tx_data holds a byte to transfer.
- busy  output  1  frame engine not IDLE.
- frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.
- overrun_cnt  output  8  saturating count of dropped frame triggers.

Behaviour:
- Reset (clk edge with reset=1):
  - tick counter=0, state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, pending=0, overrun_cnt=0, snapshot regs=8'h30.
- Tick generator:
  - Free-running counter 0..TICK_CYCLES-1, independent of FSM state.
  - Internal tick=1 for one cycle when counter==TICK_CYCLES-1, then counter wraps to 0.
  - First tick occurs TICK_CYCLES cycles after reset deasserts.
- Trigger:
  - trig = tick | send_req.
  - tick and send_req in the same cycle count as one trigger.
- FSM states: IDLE, SEND, DONE.
  - IDLE: on trig or pending, capture snapshot of tens_in, ones_in, rev_in; clear pending; set idx=0; go to SEND. tx_valid rises the next cycle (latency 1).
  - SEND:
    - tx_valid=1 and tx_data=byte[idx], both held stable until a transfer occurs.
    - A transfer is an edge where tx_valid & tx_ready are both 1.
    - On transfer: idx+1, or go to DONE if idx was the last byte.
    - tx_valid must not drop without a transfer.
  - DONE: one cycle; frame_done=1, tx_valid=0; go to IDLE.
- Back-to-back frames: a pending trigger starts the next frame from IDLE, so there is exactly 1 idle cycle between frames.
- Byte order:
  - CRLF_EN=1, 6 bytes: snap_tens, snap_ones, SEP_CHAR, snap_rev, 8'h0D, 8'h0A.
  - CRLF_EN=0: first 4 bytes only.
- Digit sanitising: a snapshot byte outside 8'h30..8'h39 is sent as 8'h3F ('?'). Zero-extend 7-bit inputs to 8 bits.
- Triggers while busy (state != IDLE):
  - If pending=0: set pending=1.
  - If pending=1 already: overrun_cnt+1, saturating at 8'hFF.
  - At most one trigger is queued; the queued frame snapshots the inputs when it starts, not when triggered.
- Trigger in the DONE cycle counts as busy (sets pending).
- tx_ready held 0 indefinitely: FSM stalls in SEND; tick generator keeps running; overrun accumulates.
- Reset mid-frame: frame aborts at that edge; tx_valid=0 the cycle after; no frame_done; pending cleared.
- busy = (state != IDLE).

Test Plan:
- TICK_CYCLES=8, tx_ready=1, inputs '4','2','7':
  - tick at cycle 8 after reset release; tx_valid from cycle 9.
  - Bytes 34,32,3A,37,0D,0A on 6 consecutive cycles.
  - frame_done pulses the cycle after the 0A transfer.
- Backpressure: tx_ready toggled 1,0,0,1 pattern → each byte held stable while valid & !ready; sequence unchanged; no byte duplicated or skipped.
- Snapshot: change tens_in from '4' to '5' after the first byte is accepted → frame still sends 34; the next frame sends 35.
- Overrun: tx_ready=0, TICK_CYCLES=8, hold 40 cycles → pending=1, overrun_cnt=3 (4 ticks after the start); on release, the current frame completes, then the queued frame starts after 1 idle cycle.
- Invalid digit: rev_in=7'h41 → byte 4 = 3F. CRLF_EN=0 → frame is exactly 4 bytes, then frame_done.
- Reset during byte 3 → next cycle: tx_valid=0, busy=0, overrun_cnt=0, no frame_done. send_req and tick together in IDLE → exactly one frame, overrun_cnt unchanged.
